// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared types and defaults for the PC sequencer
// Holds the FSM state enum, the PC width and the default STEP / RESET_PC values.
package pc_seq_pkg;
    localparam int PC_W = 8;
    localparam int STEP_DEF = 4;
    localparam logic [PC_W-1:0] RESET_PC_DEF = 8'h00;
    typedef enum logic [1:0] {RUN, FLUSH, HALT} state_t;
endpackage

// File: rtl/pc_seq_if.sv
// pc_seq_if: branch, fetch and status bus of the PC sequencer
// master: sequencer side (drives pc, fetch_req, taken, flush, halted, link)
// slave : environment side (drives cond_true, br_*, stall, fetch_ready)
interface pc_seq_if;
    import pc_seq_pkg::*;
    logic            cond_true;
    logic            br_valid;
    logic [PC_W-1:0] br_pc;
    logic [PC_W-1:0] br_target;
    logic            br_link;
    logic            stall;
    logic            fetch_ready;
    logic [PC_W-1:0] pc;
    logic            fetch_req;
    logic            taken;
    logic            flush;
    logic            halted;
    logic [PC_W-1:0] link;
    modport master (
        input  cond_true, br_valid, br_pc, br_target, br_link, stall, fetch_ready,
        output pc, fetch_req, taken, flush, halted, link
    );
    modport slave (
        output cond_true, br_valid, br_pc, br_target, br_link, stall, fetch_ready,
        input  pc, fetch_req, taken, flush, halted, link
    );
endinterface

// File: rtl/pc_seq_next.sv
// pc_seq_next: next-PC mux (branch target / increment / hold)
// Ports: pc (current), target (branch destination), sel_target, sel_inc -> pc_next.
// A taken branch has priority over an accepted fetch; the increment wraps mod 2^PC_W.
module pc_seq_next
    import pc_seq_pkg::*;
#(
    parameter int STEP = STEP_DEF
) (
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] target,
    input  logic            sel_target,
    input  logic            sel_inc,
    output logic [PC_W-1:0] pc_next
);
    always_comb pc_next = sel_target ? target : sel_inc ? pc + PC_W'(STEP) : pc;
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer with branch, flush and halt handling
// Ports: clk, rst (async, active-low), bus (pc_seq_if.master: branch inputs,
// stall, fetch handshake, pc/fetch_req/taken/flush/halted/link outputs).
// Macro PC_SEQ_BRANCH_LINK_EN: when defined, taken branches with br_link save
// br_pc+STEP into link; otherwise link is tied to zero.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF,
    parameter int              STEP     = STEP_DEF
) (
    input  logic          clk,
    input  logic          rst,
    pc_seq_if.master      bus
);
    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            taken_q, flush_q, halted_q;
    logic            go, take, accept;

    assign go     = (state_q == RUN) && !bus.stall;
    assign take   = go && bus.br_valid && bus.cond_true;
    assign accept = go && bus.fetch_ready;

    pc_seq_next #(.STEP(STEP)) u_next (
        .pc         (pc_q),
        .target     (bus.br_target),
        .sel_target (take),
        .sel_inc    (accept),
        .pc_next    (pc_d)
    );

    // Stall freezes every state, including an in-progress FLUSH.
    always_comb begin
        state_d = bus.stall ? state_q
                : (state_q == RUN)  ? (take ? ((bus.br_target == bus.br_pc) ? HALT : FLUSH) : RUN)
                : (state_q == HALT) ? HALT
                : RUN;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= RUN;
            pc_q     <= RESET_PC;
            taken_q  <= 1'b0;
            flush_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            taken_q  <= take;
            flush_q  <= state_d == FLUSH;
            halted_q <= state_d == HALT;
        end
    end

`ifdef PC_SEQ_BRANCH_LINK_EN
    logic [PC_W-1:0] link_q, link_d;
    always_comb link_d = (take && bus.br_link) ? bus.br_pc + PC_W'(STEP) : link_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) link_q <= '0;
        else      link_q <= link_d;
    end
`else
    logic [PC_W-1:0] link_q;
    logic            unused_link;
    assign link_q      = '0;
    assign unused_link = bus.br_link;
`endif

    always_comb begin
        bus.fetch_req = go;
        bus.pc        = pc_q;
        bus.taken     = taken_q;
        bus.flush     = flush_q;
        bus.halted    = halted_q;
        bus.link      = link_q;
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scoreboard bench for pc_sequencer
module tb_pc_sequencer;
    import pc_seq_pkg::*;

    typedef struct {
        logic [7:0] pc;
        logic       fr;
        logic       tk;
        logic       fl;
        logic       hl;
        logic [7:0] lk;
    } exp_t;

`ifdef PC_SEQ_BRANCH_LINK_EN
    localparam logic [7:0] L1 = 8'h34;
`else
    localparam logic [7:0] L1 = 8'h00;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    pc_seq_if bus();

    pc_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge and queue the
    // outputs expected during that cycle.
    task automatic step(input logic r, ct, bv, input logic [7:0] bpc, btg,
                        input logic bl, st, fr,
                        input logic [7:0] e_pc, input logic e_fr, e_tk, e_fl, e_hl,
                        input logic [7:0] e_lk);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r;
        bus.cond_true = ct;
        bus.br_valid = bv;
        bus.br_pc = bpc;
        bus.br_target = btg;
        bus.br_link = bl;
        bus.stall = st;
        bus.fetch_ready = fr;
        e.pc = e_pc; e.fr = e_fr; e.tk = e_tk; e.fl = e_fl; e.hl = e_hl; e.lk = e_lk;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("pc", bus.pc, e.pc);
            chk("fetch_req", {7'd0, bus.fetch_req}, {7'd0, e.fr});
            chk("taken", {7'd0, bus.taken}, {7'd0, e.tk});
            chk("flush", {7'd0, bus.flush}, {7'd0, e.fl});
            chk("halted", {7'd0, bus.halted}, {7'd0, e.hl});
            chk("link", bus.link, e.lk);
        end
    end

    initial begin
        bus.cond_true = 0; bus.br_valid = 0; bus.br_pc = 0; bus.br_target = 0;
        bus.br_link = 0; bus.stall = 1; bus.fetch_ready = 0;
        //    r ct bv bpc    btg    bl st fr   pc     fr tk fl hl lk
        step(0, 0, 0, 8'h00, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0, 0, 8'h00);
        step(1, 0, 0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 1, 0, 0, 0, 8'h00);
        step(1, 0, 0, 8'h00, 8'h00, 0, 0, 1, 8'h04, 1, 0, 0, 0, 8'h00);
        step(1, 0, 0, 8'h00, 8'h00, 0, 0, 1, 8'h08, 1, 0, 0, 0, 8'h00);
        step(1, 0, 0, 8'h00, 8'h00, 0, 0, 1, 8'h0C, 1, 0, 0, 0, 8'h00);
        // taken branch 10 -> 40
        step(1, 1, 1, 8'h10, 8'h40, 0, 0, 1, 8'h10, 1, 0, 0, 0, 8'h00);
        step(1, 0, 0, 8'h00, 8'h00, 0, 0, 1, 8'h40, 0, 1, 1, 0, 8'h00);
        step(1, 0, 0, 8'h00, 8'h00, 0, 0, 1, 8'h40, 1, 0, 0, 0, 8'h00);
        // not-taken branch behaves as increment
        step(1, 0, 1, 8'h10, 8'h40, 0, 0, 1, 8'h44, 1, 0, 0, 0, 8'h00);
        step(1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h48, 1, 0, 0, 0, 8'h00);
        step(1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h48, 1, 0, 0, 0, 8'h00);
        // stalled branch is ignored, then taken with link
        step(1, 1, 1, 8'h30, 8'h80, 1, 1, 1, 8'h48, 0, 0, 0, 0, 8'h00);
        step(1, 1, 1, 8'h30, 8'h80, 1, 0, 1, 8'h48, 1, 0, 0, 0, 8'h00);
        step(1, 0, 0, 8'h00, 8'h00, 0, 0, 1, 8'h80, 0, 1, 1, 0, L1);
        step(1, 0, 0, 8'h00, 8'h00, 0, 0, 1, 8'h80, 1, 0, 0, 0, L1);
        // branch to FC without link, then wrap to 00
        step(1, 1, 1, 8'h84, 8'hFC, 0, 0, 1, 8'h84, 1, 0, 0, 0, L1);
        step(1, 0, 0, 8'h00, 8'h00, 0, 0, 1, 8'hFC, 0, 1, 1, 0, L1);
        step(1, 0, 0, 8'h00, 8'h00, 0, 0, 1, 8'hFC, 1, 0, 0, 0, L1);
        step(1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 1, 0, 0, 0, L1);
        // self-loop -> HALT, frozen despite further branches
        step(1, 1, 1, 8'h20, 8'h20, 0, 0, 1, 8'h00, 1, 0, 0, 0, L1);
        step(1, 0, 0, 8'h00, 8'h00, 0, 0, 1, 8'h20, 0, 1, 0, 1, L1);
        for (int i = 0; i < 10; i++)
            step(1, 1, 1, 8'h00, 8'h60, 1, 0, 1, 8'h20, 0, 0, 0, 1, L1);
        // reset in HALT
        step(0, 0, 0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 1, 0, 0, 0, 8'h00);
        step(1, 0, 0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 1, 0, 0, 0, 8'h00);
        // reset mid-FLUSH leaves no residual pulse
        step(1, 1, 1, 8'h04, 8'h50, 1, 0, 1, 8'h04, 1, 0, 0, 0, 8'h00);
        step(0, 0, 0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 1, 0, 0, 0, 8'h00);
        step(1, 0, 0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 1, 0, 0, 0, 8'h00);
        step(1, 0, 0, 8'h00, 8'h00, 0, 0, 1, 8'h04, 1, 0, 0, 0, 8'h00);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("sb_drain", 8'(sb.size()), 8'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter: RESET_PC, 8'h00, PC value loaded at reset.
REQ-002 Parameter: STEP, 4, PC increment per accepted fetch (bytes per instruction).
REQ-003 Port: clk  in  1  sole clock, rising edge.
REQ-004 Port: rst  in  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005 Port: cond_true  in  1  result from upstream condition evaluator for the current branch.
REQ-006 Port: br_valid  in  1  current instruction is a conditional branch.
REQ-007 Port: br_pc  in  8  address of the branch instruction.
REQ-008 Port: br_target  in  8  branch destination address.
REQ-009 Port: br_link  in  1  branch requests link save.
REQ-010 Port: stall  in  1  downstream hold; freezes sequencing.
REQ-011 Port: fetch_ready  in  1  instruction memory accepts fetch this cycle.
REQ-012 Port: pc  out  8  current fetch address.
REQ-013 Port: fetch_req  out  1  fetch request at pc.
REQ-014 Port: taken  out  1  registered one-cycle pulse, branch taken.
REQ-015 Port: flush  out  1  discard the in-flight instruction.
REQ-016 Port: halted  out  1  sequencer halted.
REQ-017 Port: link  out  8  saved return address.

Function
REQ-018 FSM states RUN, FLUSH, HALT shall be used; FSM resets to RUN.
REQ-019 fetch_req shall be 1 only in RUN with stall=0.
REQ-020 In RUN: fetch_req & fetch_ready & no taken branch -> pc <= pc+STEP, mod 256 (wraps, e.g. 8'hFC -> 8'h00).
REQ-021 Taken branch = RUN & !stall & br_valid & cond_true; pc <= br_target next cycle, taken=1 for exactly that cycle, FSM -> FLUSH.
REQ-022 Taken branch shall override a simultaneous fetch acceptance; that increment is discarded.
REQ-023 br_valid & !cond_true shall behave exactly as a normal increment cycle.
REQ-024 FLUSH lasts one cycle: flush=1, fetch_req=0, pc held; then -> RUN.
REQ-025 Taken branch with br_target == br_pc (self-loop) -> HALT instead of FLUSH; pc <= br_target.
REQ-026 HALT: halted=1, fetch_req=0, pc frozen; exit only via reset.
REQ-027 stall=1 shall freeze pc, FSM and link, and br_valid shall be ignored that cycle; upstream holds the branch until stall=0.
REQ-028 taken, flush, halted shall be registered outputs; no combinational input-to-output path except fetch_req from stall.

Reset
REQ-029 rst=0 shall immediately force pc=RESET_PC, FSM=RUN, taken=0, flush=0, halted=0, link=8'h00, regardless of clk.
REQ-030 Reset asserted mid-FLUSH or in HALT shall return to RUN with no residual taken/flush pulse after release.
REQ-031 First fetch_req shall occur in the first cycle after rst deasserts, at RESET_PC.

Configuration
REQ-032 Macro PC_SEQ_BRANCH_LINK_EN defined: a taken branch with br_link=1 loads link <= br_pc+STEP (mod 256), held until the next such branch or reset.
REQ-033 Macro undefined: link port present, constant 8'h00; br_link ignored; no link register synthesized.

Structure
REQ-034 Shared package pc_seq_pkg shall hold the FSM state enum, PC_W=8 and the STEP/RESET_PC defaults.
REQ-035 One combinational sub-module pc_seq_next shall compute next-PC (increment/target/hold mux); FSM and registers stay in pc_sequencer.

Verification
REQ-036 Reset release, fetch_ready=1 for 4 cycles -> pc 00,04,08,0C; fetch_req=1 throughout.
REQ-037 pc=FC, fetch accepted -> pc=00 next cycle, no taken, no flush.
REQ-038 br_valid=1, cond_true=1, br_pc=10, br_target=40, fetch_ready=1 -> pc=40, taken=1 for 1 cycle, flush=1 next cycle, fetch_req=0 in FLUSH, then RUN at 40.
REQ-039 Same branch with cond_true=0 -> pc advances by 4; taken=0, flush=0.
REQ-040 br_pc=20, br_target=20, cond_true=1 -> halted=1, pc=20 frozen for 10 cycles; rst=0 pulse -> pc=00, halted=0.
REQ-041 With macro: taken branch br_pc=30, br_link=1 -> link=34; stall=1 during a branch -> no pc/link change; macro undefined -> link=00.
